// File: rtl/inst_mem_pkg.sv
// rtl/inst_mem_pkg.sv - shared types and constants for the loadable instruction memory
//
// Purpose : FSM state encoding, fault codes and the loaded-word counter
//           width helper used by the interface and the top module.
// Ports   : none (package).
package inst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_RANGE    = 2'b10;

  // Width able to hold every count from 0 to depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/inst_mem_loadable_if.sv
// rtl/inst_mem_loadable_if.sv - load handshake and fetch bus of the instruction memory
//
// Purpose : bundles the image-load handshake and the IF-stage fetch port.
// Modports:
//   master - loader/core side: drives load_start, load_valid, load_data,
//            load_last, pc, fetch_req, stall; observes load_ready,
//            loaded_words, instruction, instr_valid, fault, busy.
//   slave  - memory side, directions reversed.
interface inst_mem_loadable_if
  import inst_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic [CNT_W-1:0]  loaded_words;
  logic [ADDR_W-1:0] pc;
  logic              fetch_req;
  logic              stall;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic [1:0]        fault;
  logic              busy;

  modport master (
    output load_start, load_valid, load_data, load_last, pc, fetch_req, stall,
    input  load_ready, loaded_words, instruction, instr_valid, fault, busy
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, pc, fetch_req, stall,
    output load_ready, loaded_words, instruction, instr_valid, fault, busy
  );

endinterface

// File: rtl/inst_mem_array.sv
// rtl/inst_mem_array.sv - DEPTH x DATA_W storage, one write port, one registered read port
//
// Purpose : instruction word storage; contents are never reset.
// Ports   :
//   clk   in  rising-edge clock
//   we    in  write enable
//   waddr in  write word index
//   wdata in  write data
//   re    in  read enable; rdata holds its value while low
//   raddr in  read word index
//   rdata out registered read data
module inst_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/inst_mem_loadable.sv
// rtl/inst_mem_loadable.sv - run-time loadable instruction memory with faulting fetch port
//
// Purpose : accepts an instruction image through a sequential load
//           handshake, then serves registered fetches with misaligned and
//           out-of-range fault reporting.
// Ports   :
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  slave modport of inst_mem_loadable_if (load handshake + fetch port)
module inst_mem_loadable
  import inst_mem_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter int              DEPTH     = 64,
  parameter int              ADDR_W    = 32,
  parameter int              BYTE_ADDR = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst,
  inst_mem_loadable_if.slave bus
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CMP_W = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;

  state_t           state, state_n;
  // The write pointer doubles as the loaded word count: every accepted
  // word advances both, and both restart together.
  logic [CNT_W-1:0] wptr, wptr_n;
  logic [CNT_W-1:0] base_ptr;
  logic             in_load, in_run;
  logic             accept, done;

  assign in_load = (state == LOAD);
  assign in_run  = (state == RUN);

  assign bus.load_ready   = in_load;
  assign bus.busy         = !in_run;
  assign bus.loaded_words = wptr;

  // A load_start seen in LOAD restarts the image; a word offered in the
  // same cycle lands at index 0.
  assign base_ptr = bus.load_start ? '0 : wptr;
  assign accept   = in_load && bus.load_valid;
  assign done     = accept && (bus.load_last || (base_ptr == CNT_W'(DEPTH - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wptr  <= '0;
    end else begin
      state <= state_n;
      wptr  <= wptr_n;
    end
  end

  always_comb begin
    state_n = state;
    wptr_n  = wptr;
    case (state)
      IDLE: begin
        if (bus.load_start) begin
          state_n = LOAD;
          wptr_n  = '0;
        end
      end
      LOAD: begin
        wptr_n = base_ptr + CNT_W'(accept);
        if (done) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (bus.load_start) begin
          state_n = LOAD;
          wptr_n  = '0;
        end
      end
      default: begin
        state_n = IDLE;
        wptr_n  = '0;
      end
    endcase
  end

  // Fetch decode. The full index is compared against the count so that
  // high pc bits can never alias onto a loaded word.
  logic [ADDR_W-1:0] widx;
  logic              misaligned, out_range, serve;
  logic [1:0]        flt;

  assign widx       = (BYTE_ADDR != 0) ? (bus.pc >> 2) : bus.pc;
  assign misaligned = (BYTE_ADDR != 0) && (bus.pc[1:0] != 2'b00);
  assign out_range  = CMP_W'(widx) >= CMP_W'(wptr);
  assign flt        = misaligned ? FLT_MISALIGN : (out_range ? FLT_RANGE : FLT_NONE);
  // A reload requested in the same cycle takes precedence over the fetch.
  assign serve      = in_run && bus.fetch_req && !bus.load_start;

  logic [DATA_W-1:0] rdata;
  logic              valid_q, use_mem_q;
  logic [1:0]        fault_q;

  inst_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk   (clk),
    .we    (accept),
    .waddr (base_ptr[AW-1:0]),
    .wdata (bus.load_data),
    .re    (serve && !bus.stall),
    .raddr (widx[AW-1:0]),
    .rdata (rdata)
  );

  // use_mem_q selects the array read register; it is cleared for faults
  // and idle cycles so the output shows NOP_WORD without resetting storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      fault_q   <= FLT_NONE;
      use_mem_q <= 1'b0;
    end else if (!bus.stall) begin
      if (serve) begin
        valid_q   <= 1'b1;
        fault_q   <= flt;
        use_mem_q <= (flt == FLT_NONE);
      end else begin
        valid_q   <= 1'b0;
        fault_q   <= FLT_NONE;
        use_mem_q <= 1'b0;
      end
    end
  end

  assign bus.instruction = use_mem_q ? rdata : NOP_WORD;
  assign bus.instr_valid = valid_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// tb/tb_inst_mem_loadable.sv - self-checking bench for inst_mem_loadable
module tb_inst_mem_loadable;

  localparam int DEPTH = 64;

  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic [1:0]  fault;
  } out_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        req;
    logic [31:0] instr;
    logic        valid;
    logic [1:0]  fault;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  out_t sb_q[$];
  logic [31:0] full_img [DEPTH];

  inst_mem_loadable_if #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32)) bus ();

  inst_mem_loadable #(
    .DATA_W    (32),
    .DEPTH     (DEPTH),
    .ADDR_W    (32),
    .BYTE_ADDR (1),
    .NOP_WORD  (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".instruction"}, bus.instruction, 32'h0);
    check({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'h0);
    check({tag, ".fault"}, 32'(bus.fault), 32'h0);
    check({tag, ".load_ready"}, 32'(bus.load_ready), 32'h0);
    check({tag, ".busy"}, 32'(bus.busy), 32'h1);
    check({tag, ".loaded_words"}, 32'(bus.loaded_words), 32'h0);
  endtask

  // One clock with the given fetch inputs; the expectation goes through
  // the scoreboard and is compared once the output register has updated.
  task automatic cycle_fetch(input string tag, input logic [31:0] p, input logic req,
                             input logic stl, input out_t e);
    out_t got_exp;
    bus.pc        = p;
    bus.fetch_req = req;
    bus.stall     = stl;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got_exp = sb_q.pop_front();
    check({tag, ".instruction"}, bus.instruction, got_exp.instr);
    check({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(got_exp.valid));
    check({tag, ".fault"}, 32'(bus.fault), 32'(got_exp.fault));
    bus.fetch_req = 1'b0;
    bus.stall     = 1'b0;
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    @(posedge clk);
    #1;
    bus.load_start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    while (bus.load_ready !== 1'b1 && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("load_ready_wait", 32'(bus.load_ready), 32'h1);
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  initial begin
    vec_t vecs[10];
    vecs[0] = '{32'h0000_0000, 1'b1, 32'h8C00_03E8, 1'b1, 2'b00};
    vecs[1] = '{32'h0000_0004, 1'b1, 32'h0022_1020, 1'b1, 2'b00};
    vecs[2] = '{32'h0000_0008, 1'b1, 32'hAC02_07D0, 1'b1, 2'b00};
    vecs[3] = '{32'h0000_000C, 1'b1, 32'h0000_0000, 1'b1, 2'b10};
    vecs[4] = '{32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 2'b01};
    vecs[5] = '{32'h0000_000D, 1'b1, 32'h0000_0000, 1'b1, 2'b01};
    vecs[6] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 2'b00};
    vecs[7] = '{32'h4000_0000, 1'b1, 32'h0000_0000, 1'b1, 2'b10};
    vecs[8] = '{32'h0000_0100, 1'b1, 32'h0000_0000, 1'b1, 2'b10};
    vecs[9] = '{32'h0000_0008, 1'b1, 32'hAC02_07D0, 1'b1, 2'b00};

    for (int i = 0; i < DEPTH; i++) full_img[i] = 32'hA500_0000 + 32'(i) * 32'h0000_0101;

    checks         = 0;
    errors         = 0;
    rst            = 1'b0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 32'h0;
    bus.load_last  = 1'b0;
    bus.pc         = 32'h0;
    bus.fetch_req  = 1'b0;
    bus.stall      = 1'b0;

    // Reset state.
    #2 rst = 1'b1;
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Three-word image with load_last on the third word.
    pulse_start();
    check("load.busy_in_load", 32'(bus.busy), 32'h1);
    send_word(32'h8C00_03E8, 1'b0);
    send_word(32'h0022_1020, 1'b0);
    check("load.busy_before_last", 32'(bus.busy), 32'h1);
    check("load.loaded_two", 32'(bus.loaded_words), 32'd2);
    send_word(32'hAC02_07D0, 1'b1);
    check("load.busy_after_last", 32'(bus.busy), 32'h0);
    check("load.loaded_three", 32'(bus.loaded_words), 32'd3);
    check("load.ready_in_run", 32'(bus.load_ready), 32'h0);

    // Table-driven fetches: hits, range boundary, misalignment priority, wide pc.
    for (int i = 0; i < 10; i++) begin
      cycle_fetch($sformatf("vec%0d", i), vecs[i].pc, vecs[i].req, 1'b0,
                  '{vecs[i].instr, vecs[i].valid, vecs[i].fault});
    end

    // Stall holds the output while pc moves on; release serves the current pc.
    cycle_fetch("stall.pre", 32'h4, 1'b1, 1'b0, '{32'h0022_1020, 1'b1, 2'b00});
    for (int i = 0; i < 3; i++) begin
      cycle_fetch($sformatf("stall.hold%0d", i), 32'h8, 1'b1, 1'b1, '{32'h0022_1020, 1'b1, 2'b00});
    end
    cycle_fetch("stall.release", 32'h8, 1'b1, 1'b0, '{32'hAC02_07D0, 1'b1, 2'b00});

    // Full-depth fill without load_last.
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      send_word(full_img[i], 1'b0);
      if (i == DEPTH - 2) check("full.busy_before_end", 32'(bus.busy), 32'h1);
    end
    check("full.busy_after_end", 32'(bus.busy), 32'h0);
    check("full.loaded_words", 32'(bus.loaded_words), 32'(DEPTH));
    cycle_fetch("full.last", 32'(4 * (DEPTH - 1)), 1'b1, 1'b0, '{full_img[DEPTH-1], 1'b1, 2'b00});
    cycle_fetch("full.beyond", 32'(4 * DEPTH), 1'b1, 1'b0, '{32'h0, 1'b1, 2'b10});
    bus.load_valid = 1'b1;
    bus.load_data  = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("full.no_ready%0d", i), 32'(bus.load_ready), 32'h0);
      @(posedge clk);
      #1;
    end
    bus.load_valid = 1'b0;
    check("full.loaded_kept", 32'(bus.loaded_words), 32'(DEPTH));
    cycle_fetch("full.word0", 32'h0, 1'b1, 1'b0, '{full_img[0], 1'b1, 2'b00});

    // Reload requested together with a fetch: load wins.
    bus.load_start = 1'b1;
    cycle_fetch("reload.fetch_dropped", 32'h0, 1'b1, 1'b0, '{32'h0, 1'b0, 2'b00});
    bus.load_start = 1'b0;
    check("reload.busy", 32'(bus.busy), 32'h1);
    check("reload.loaded_zero", 32'(bus.loaded_words), 32'h0);
    check("reload.ready", 32'(bus.load_ready), 32'h1);
    send_word(32'h1111_1111, 1'b0);
    // Restart inside LOAD with a word in the same cycle: it goes to index 0.
    bus.load_start = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    check("restart.loaded_one", 32'(bus.loaded_words), 32'd1);
    check("restart.busy", 32'(bus.busy), 32'h1);
    send_word(32'h1234_5678, 1'b1);
    check("restart.loaded_two", 32'(bus.loaded_words), 32'd2);
    cycle_fetch("restart.word0", 32'h0, 1'b1, 1'b0, '{32'hCAFE_F00D, 1'b1, 2'b00});
    cycle_fetch("restart.word1", 32'h4, 1'b1, 1'b0, '{32'h1234_5678, 1'b1, 2'b00});
    cycle_fetch("restart.range", 32'h8, 1'b1, 1'b0, '{32'h0, 1'b1, 2'b10});

    // Asynchronous reset in the middle of a five-word load.
    pulse_start();
    send_word(32'h0BAD_0001, 1'b0);
    send_word(32'h0BAD_0002, 1'b0);
    check("midrst.loaded_before", 32'(bus.loaded_words), 32'd2);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    send_word(32'hDEAD_BEEF, 1'b1);
    check("midrst.loaded_one", 32'(bus.loaded_words), 32'd1);
    cycle_fetch("midrst.pc4", 32'h4, 1'b1, 1'b0, '{32'h0, 1'b1, 2'b10});
    cycle_fetch("midrst.pc0", 32'h0, 1'b1, 1'b0, '{32'hDEAD_BEEF, 1'b1, 2'b00});

    check("scoreboard.empty", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
